pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with an optional 2-entry skid buffer, a bubble-encoded
// control bundle, synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] CTRL_NOP = 24'h000001,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_xfer, out_xfer;
    logic              load_main_in, load_main_skid, load_skid, clr_ctrl;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (in_xfer) state_nxt = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_nxt = (SKID != 0) ? TWO : ONE;
                    else if (!in_xfer && out_xfer) state_nxt = EMPTY;
                end
                TWO:     if (out_xfer) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready with the skid buffer looks only at state, so out_ready never reaches it.
    always_comb begin
        out_valid = (state != EMPTY);
        if (SKID != 0) in_ready = !rst && !flush && (state != TWO);
        else           in_ready = !rst && !flush && (!out_valid || out_ready);
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clr_ctrl       = 1'b0;
        case (state)
            EMPTY: load_main_in = in_xfer;
            ONE: begin
                load_main_in = in_xfer && out_xfer;
                load_skid    = in_xfer && !out_xfer && (SKID != 0);
                clr_ctrl     = !in_xfer && out_xfer;
            end
            TWO:     load_main_skid = out_xfer;
            default: clr_ctrl = 1'b1;
        endcase
    end

    // Flush only bubbles the control; payload registers keep their last contents.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ctrl  <= CTRL_NOP;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            out_ctrl <= CTRL_NOP;
        end else begin
            if (load_main_in) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                out_data <= skid_data;
                out_ctrl <= skid_ctrl;
            end else if (clr_ctrl) begin
                out_ctrl <= CTRL_NOP;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks on a skid-buffered stage plus a random back-pressure scoreboard
// run on both the skid and single-entry variants.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [3:0]  a_stall;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [3:0]  b_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_NOP(8'h01), .SKID(1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_NOP(8'h01), .SKID(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic a_send(input logic [31:0] d, input logic [7:0] c);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_ctrl  = c;
    endtask

    int          a_seq, b_seq;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];

    // Scoreboard step: called with inputs settled, just before the falling edge.
    task automatic sb_step();
        logic [31:0] e;
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) chk("a_extra_out", 32'd1, 32'd0);
            else begin
                e = a_q.pop_front();
                chk("a_rand_data", a_out_data, e);
                chk("a_rand_ctrl", {24'd0, a_out_ctrl}, {24'd0, e[7:0] ^ 8'hA5});
            end
        end
        if (a_in_valid && a_in_ready) begin
            a_q.push_back(a_seq);
            a_seq++;
        end
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) chk("b_extra_out", 32'd1, 32'd0);
            else begin
                e = b_q.pop_front();
                chk("b_rand_data", b_out_data, e);
                chk("b_rand_ctrl", {24'd0, b_out_ctrl}, {24'd0, e[7:0] ^ 8'hA5});
            end
        end
        if (b_in_valid && b_in_ready) begin
            b_q.push_back(b_seq);
            b_seq++;
        end
    endtask

    initial begin
        logic r0;
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = 0; a_in_ctrl = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = 0; b_in_ctrl = 0;
        #2;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_ctrl", a_out_ctrl, 8'h01);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_stall", a_stall, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", a_in_ready, 1);

        // pass-through
        a_out_ready = 1'b1;
        a_send(32'hA, 8'h33);
        tick();
        chk("pt_valid", a_out_valid, 1);
        chk("pt_data", a_out_data, 32'hA);
        chk("pt_ctrl", a_out_ctrl, 8'h33);
        a_in_valid = 1'b0;
        tick();
        chk("pt_empty_valid", a_out_valid, 0);
        chk("pt_empty_ctrl", a_out_ctrl, 8'h01);

        // skid fill, then drain in order
        a_out_ready = 1'b0;
        a_send(32'h1, 8'h11);
        tick();
        chk("sk_one_ready", a_in_ready, 1);
        a_send(32'h2, 8'h22);
        tick();
        chk("sk_two_ready", a_in_ready, 0);
        chk("sk_two_data", a_out_data, 32'h1);
        a_send(32'h3, 8'h33);
        tick();
        chk("sk_hold_data", a_out_data, 32'h1);
        chk("sk_hold_ctrl", a_out_ctrl, 8'h11);
        chk("sk_stall", a_stall, 4'd2);
        a_out_ready = 1'b1;
        tick();
        chk("sk_b_data", a_out_data, 32'h2);
        chk("sk_b_ctrl", a_out_ctrl, 8'h22);
        tick();
        chk("sk_c_data", a_out_data, 32'h3);
        chk("sk_c_ctrl", a_out_ctrl, 8'h33);
        a_in_valid = 1'b0;
        tick();
        chk("sk_done_valid", a_out_valid, 0);
        chk("sk_done_ctrl", a_out_ctrl, 8'h01);

        // flush priority while full
        a_out_ready = 1'b0;
        a_send(32'h4, 8'h44);
        tick();
        a_send(32'h5, 8'h55);
        tick();
        a_flush = 1'b1; a_out_ready = 1'b1;
        a_send(32'h6, 8'h66);
        #1;
        chk("fl_ready_low", a_in_ready, 0);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        #1;
        chk("fl_valid", a_out_valid, 0);
        chk("fl_ctrl", a_out_ctrl, 8'h01);
        chk("fl_ready", a_in_ready, 1);
        chk("fl_data_hold", a_out_data, 32'h4);
        tick();
        chk("fl_stays_empty", a_out_valid, 0);
        chk("fl_stall", a_stall, 4'd3);

        // stall counter saturation, untouched by flush
        a_out_ready = 1'b0;
        a_send(32'h7, 8'h77);
        tick();
        a_in_valid = 1'b0;
        repeat (20) tick();
        chk("st_sat", a_stall, 4'hF);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        #1;
        chk("st_after_flush", a_stall, 4'hF);
        chk("st_flush_valid", a_out_valid, 0);

        // async reset while full
        a_send(32'h8, 8'h88);
        tick();
        a_send(32'h9, 8'h99);
        tick();
        a_in_valid = 1'b0;
        chk("ar_full", a_in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", a_out_valid, 0);
        chk("ar_ctrl", a_out_ctrl, 8'h01);
        chk("ar_stall", a_stall, 0);
        chk("ar_data", a_out_data, 0);
        rst = 1'b0;
        #1;
        chk("ar_ready", a_in_ready, 1);
        tick();
        chk("ar_no_partial", a_out_valid, 0);

        // random back-pressure, both variants
        a_seq = 100; b_seq = 5000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_in_data   = a_seq;
            a_in_ctrl   = a_in_data[7:0] ^ 8'hA5;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_in_data   = b_seq;
            b_in_ctrl   = b_in_data[7:0] ^ 8'hA5;
            #1;
            if (cyc % 8 == 0) begin
                r0 = a_in_ready;
                a_out_ready = !a_out_ready;
                #1;
                chk("rdy_no_comb_path", a_in_ready, r0);
                a_out_ready = !a_out_ready;
                #1;
            end
            sb_step();
            tick();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (4) begin
            #1;
            sb_step();
            tick();
        end
        chk("a_lossless", a_q.size(), 0);
        chk("b_lossless", b_q.size(), 0);
        chk("a_progress", a_seq > 3000, 1);
        chk("b_progress", b_seq > 7000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
